// File: rtl/sdram_read_frame.sv
// Avalon-MM burst read master: fetches one frame from a selected DDR buffer and
// streams it out as 64-bit words, issuing bursts only when the FIFO has room for them.
module sdram_read_frame #(
    parameter int BURST_LEN    = 32,
    parameter int FRAME_BURSTS = 2400,
    parameter int FIFO_DEPTH   = 128
) (
    input  logic        clk_200,
    input  logic        reset_n,
    input  logic        start_frame,
    input  logic        buf_sel,
    input  logic [31:0] reg_addr_buf_1,
    input  logic [31:0] reg_addr_buf_2,
    output logic [28:0] avl_address,
    output logic        avl_read,
    output logic [7:0]  avl_burstcount,
    output logic [7:0]  avl_byteenable,
    input  logic        avl_waitrequest,
    input  logic [63:0] avl_readdata,
    input  logic        avl_readdatavalid,
    output logic [63:0] data_out,
    output logic        valid_out,
    input  logic        ready_in,
    output logic        busy,
    output logic        end_frame,
    output logic        err_spurious,
    output logic [1:0]  fsm_state
);

    // Stream handshake: a word moves when valid_out & ready_in are both high at a
    // rising clk_200 edge; valid_out/data_out never change while valid_out & !ready_in.
    // Avalon side: a burst is accepted on an edge where avl_read & !avl_waitrequest.

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int OW = AW + 1;
    localparam int SW = OW + 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        REQ   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t state, state_next;

    logic [28:0]   addr;
    logic [15:0]   bursts_left;
    logic [23:0]   beats_left;
    logic [OW-1:0] outstanding;

    logic [63:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [OW-1:0] mem_count;

    logic          start_ok;
    logic          accept;
    logic          beat_ok;
    logic          beat_bad;
    logic          out_free;
    logic          mem_rd;
    logic          mem_wr;
    logic          bypass;
    logic [OW:0]   fifo_used;
    logic [SW-1:0] credit_sum;
    logic          credit_ok;
    logic          fifo_empty;
    logic          drain_done;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{reg_addr_buf_1[31:29], reg_addr_buf_2[31:29]};

    assign start_ok = (state == IDLE) && start_frame;
    assign accept   = (state == REQ) && !avl_waitrequest;
    assign beat_ok  = avl_readdatavalid && (outstanding != '0);
    assign beat_bad = avl_readdatavalid && (outstanding == '0);

    // The output register refills from the FIFO, or straight from the bus when the
    // FIFO is empty, so the first beat reaches valid_out one cycle after it arrives.
    assign out_free = !valid_out || ready_in;
    assign mem_rd   = out_free && (mem_count != '0);
    assign bypass   = out_free && (mem_count == '0) && beat_ok;
    assign mem_wr   = beat_ok && !bypass;

    // Words held (FIFO plus output register) plus words still owed by the slave.
    assign fifo_used  = {1'b0, mem_count} + {{OW{1'b0}}, valid_out};
    assign credit_sum = SW'(fifo_used) + SW'(outstanding) + SW'(BURST_LEN);
    assign credit_ok  = credit_sum <= SW'(FIFO_DEPTH);
    assign fifo_empty = (mem_count == '0) && !valid_out;
    assign drain_done = (beats_left == '0) && fifo_empty;

    always_comb begin
        state_next = state;
        end_frame  = 1'b0;
        case (state)
            IDLE: begin
                if (start_frame) state_next = REQ;
            end
            CHECK: begin
                if (bursts_left == '0) state_next = DRAIN;
                else if (credit_ok)    state_next = REQ;
            end
            REQ: begin
                if (!avl_waitrequest) state_next = CHECK;
            end
            DRAIN: begin
                if (drain_done) begin
                    end_frame  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_200 or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            addr         <= '0;
            bursts_left  <= '0;
            beats_left   <= '0;
            outstanding  <= '0;
            err_spurious <= 1'b0;
        end else begin
            state <= state_next;

            if (start_ok) begin
                addr         <= buf_sel ? reg_addr_buf_2[28:0] : reg_addr_buf_1[28:0];
                bursts_left  <= 16'(FRAME_BURSTS);
                err_spurious <= 1'b0;
            end else if (accept) begin
                addr        <= addr + 29'(BURST_LEN);
                bursts_left <= bursts_left - 16'd1;
            end

            case ({accept, beat_ok})
                2'b10:   outstanding <= outstanding + OW'(BURST_LEN);
                2'b01:   outstanding <= outstanding - OW'(1);
                2'b11:   outstanding <= outstanding + OW'(BURST_LEN - 1);
                default: outstanding <= outstanding;
            endcase

            if (start_ok)     beats_left <= 24'(FRAME_BURSTS * BURST_LEN);
            else if (beat_ok) beats_left <= beats_left - 24'd1;

            if (beat_bad) err_spurious <= 1'b1;
        end
    end

    always_ff @(posedge clk_200 or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mem_count <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
        end else begin
            if (mem_wr) wr_ptr <= wr_ptr + AW'(1);
            if (mem_rd) rd_ptr <= rd_ptr + AW'(1);
            mem_count <= mem_count + OW'(mem_wr) - OW'(mem_rd);

            if (out_free) begin
                if (mem_rd) begin
                    data_out  <= mem[rd_ptr];
                    valid_out <= 1'b1;
                end else if (bypass) begin
                    data_out  <= avl_readdata;
                    valid_out <= 1'b1;
                end else begin
                    valid_out <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_200) begin
        if (mem_wr) mem[wr_ptr] <= avl_readdata;
    end

    assign avl_read       = (state == REQ);
    assign avl_address    = addr;
    assign avl_burstcount = 8'(BURST_LEN);
    assign avl_byteenable = 8'hFF;
    assign busy           = (state != IDLE);
    assign fsm_state      = state;

endmodule

// File: tb/tb_sdram_read_frame.sv
// Bench for sdram_read_frame: a burst-returning Avalon slave, a frame-level
// expected-word model, and a per-cycle stream compare against that model.
`timescale 1ns/1ps
module tb_sdram_read_frame;

    localparam int BL = 32;
    localparam int FB = 4;
    localparam int FD = 64;
    localparam int FW = BL * FB;

    logic        clk_200 = 1'b0;
    logic        reset_n;
    logic        start_frame;
    logic        buf_sel;
    logic [31:0] reg_addr_buf_1;
    logic [31:0] reg_addr_buf_2;
    logic [28:0] avl_address;
    logic        avl_read;
    logic [7:0]  avl_burstcount;
    logic [7:0]  avl_byteenable;
    logic        avl_waitrequest;
    logic [63:0] avl_readdata;
    logic        avl_readdatavalid;
    logic [63:0] data_out;
    logic        valid_out;
    logic        ready_in;
    logic        busy;
    logic        end_frame;
    logic        err_spurious;
    logic [1:0]  fsm_state_unused;

    sdram_read_frame #(.BURST_LEN(BL), .FRAME_BURSTS(FB), .FIFO_DEPTH(FD)) dut (
        .clk_200(clk_200), .reset_n(reset_n), .start_frame(start_frame), .buf_sel(buf_sel),
        .reg_addr_buf_1(reg_addr_buf_1), .reg_addr_buf_2(reg_addr_buf_2),
        .avl_address(avl_address), .avl_read(avl_read), .avl_burstcount(avl_burstcount),
        .avl_byteenable(avl_byteenable), .avl_waitrequest(avl_waitrequest),
        .avl_readdata(avl_readdata), .avl_readdatavalid(avl_readdatavalid),
        .data_out(data_out), .valid_out(valid_out), .ready_in(ready_in), .busy(busy),
        .end_frame(end_frame), .err_spurious(err_spurious), .fsm_state(fsm_state_unused)
    );

    // ---------------- clock ----------------
    always #5 clk_200 = ~clk_200;

    // ---------------- scoreboard state ----------------
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] exp_q[$];
    logic [28:0] exp_addr_q[$];
    logic [31:0] frame_id = 0;
    int          cyc = 0;
    int          accepts = 0;
    int          read_high = 0;
    int          stall_used = 0;
    int          stall_budget = 0;
    int          spur_cnt = 0;
    int          spur_served = 0;
    int          ef_count = 0;
    logic [1:0]  beat_hist = 2'b00;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame word k of a frame at base is the word at base+k (29-bit wrap), tagged with the frame id.
    function automatic logic [63:0] model_word(input logic [28:0] base, input int k, input logic [31:0] id);
        logic [28:0] a;
        a = base + 29'(k);
        return {3'b000, a, id};
    endfunction

    task automatic load_frame(input logic [28:0] base);
        frame_id = frame_id + 1;
        for (int k = 0; k < FW; k++) exp_q.push_back(model_word(base, k, frame_id));
    endtask

    task automatic tick();
        @(posedge clk_200);
        #1;
    endtask

    task automatic start(input logic sel);
        tick();
        start_frame = 1'b1;
        buf_sel     = sel;
        tick();
        start_frame = 1'b0;
    endtask

    task automatic wait_end(input string name);
        int e0;
        int n;
        e0 = ef_count;
        n  = 0;
        while (ef_count == e0 && n < 3000) begin
            @(posedge clk_200);
            n++;
        end
        #1;
        chk({name, "_end_frame_count"}, 64'(ef_count - e0), 64'd1);
    endtask

    task automatic post_frame(input string name, input int a0);
        repeat (3) tick();
        chk({name, "_busy_after"}, 64'(busy), 64'd0);
        chk({name, "_words_left"}, 64'(exp_q.size()), 64'd0);
        chk({name, "_addrs_left"}, 64'(exp_addr_q.size()), 64'd0);
        chk({name, "_bursts"}, 64'(accepts - a0), 64'(FB));
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_avl_read"}, 64'(avl_read), 64'd0);
        chk({name, "_avl_address"}, 64'(avl_address), 64'd0);
        chk({name, "_burstcount"}, 64'(avl_burstcount), 64'd32);
        chk({name, "_byteenable"}, 64'(avl_byteenable), 64'hFF);
        chk({name, "_data_out"}, data_out, 64'd0);
        chk({name, "_valid_out"}, 64'(valid_out), 64'd0);
        chk({name, "_busy"}, 64'(busy), 64'd0);
        chk({name, "_end_frame"}, 64'(end_frame), 64'd0);
        chk({name, "_err_spurious"}, 64'(err_spurious), 64'd0);
    endtask

    // ---------------- Avalon slave driver ----------------
    // Returns BL beats per accepted burst, first beat 2 cycles after accept, bursts back to back.
    initial begin
        logic [28:0] bq_addr[$];
        int          bq_due[$];
        int          last_due;
        int          d;
        logic        acc;
        logic        prev_acc;
        logic        beat;
        avl_waitrequest   = 1'b0;
        avl_readdatavalid = 1'b0;
        avl_readdata      = 64'd0;
        last_due = 0;
        prev_acc = 1'b0;
        forever begin
            @(negedge clk_200);
            cyc++;
            if (!reset_n) begin
                bq_addr.delete();
                bq_due.delete();
                exp_addr_q.delete();
                avl_waitrequest   = 1'b0;
                avl_readdatavalid = 1'b0;
                prev_acc  = 1'b0;
                beat_hist = 2'b00;
                continue;
            end
            if (avl_read) read_high++;
            if (prev_acc) chk("read_gap_between_bursts", 64'(avl_read), 64'd0);
            if (avl_read && stall_used < stall_budget) begin
                avl_waitrequest = 1'b1;
                stall_used++;
                chk("stall_address_stable", 64'(avl_address),
                    (exp_addr_q.size() > 0) ? 64'(exp_addr_q[0]) : 64'hFFFF_FFFF);
            end else begin
                avl_waitrequest = 1'b0;
            end
            acc = avl_read && !avl_waitrequest;
            if (acc) begin
                accepts++;
                if (exp_addr_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_burst: address %0h with no burst expected", avl_address);
                end else begin
                    chk("burst_address", 64'(avl_address), 64'(exp_addr_q.pop_front()));
                end
                d = (cyc + 2 > last_due + 1) ? cyc + 2 : last_due + 1;
                for (int i = 0; i < BL; i++) begin
                    bq_addr.push_back(avl_address + 29'(i));
                    bq_due.push_back(d + i);
                end
                last_due = d + BL - 1;
            end
            prev_acc = acc;
            if (bq_due.size() > 0 && bq_due[0] == cyc) begin
                avl_readdatavalid = 1'b1;
                avl_readdata      = {3'b000, bq_addr.pop_front(), frame_id};
                void'(bq_due.pop_front());
                beat = 1'b1;
            end else if (spur_cnt != spur_served) begin
                avl_readdatavalid = 1'b1;
                avl_readdata      = 64'hBAD0_BAD0_BAD0_BAD0;
                spur_served++;
                beat = 1'b1;
            end else begin
                avl_readdatavalid = 1'b0;
                beat = 1'b0;
            end
            beat_hist = {beat_hist[0], beat};
        end
    end

    // ---------------- stream compare ----------------
    initial begin
        logic prev_valid;
        logic prev_ef;
        logic prev_pop;
        prev_valid = 1'b0;
        prev_ef    = 1'b0;
        prev_pop   = 1'b0;
        forever begin
            @(negedge clk_200);
            #2;
            if (!reset_n) begin
                exp_q.delete();
                prev_valid = 1'b0;
                prev_ef    = 1'b0;
                prev_pop   = 1'b0;
                continue;
            end
            if (end_frame) begin
                ef_count++;
                chk("end_frame_words_done", 64'(exp_q.size()), 64'd0);
                chk("end_frame_after_last_word", 64'(prev_pop), 64'd1);
                chk("end_frame_busy", 64'(busy), 64'd1);
                chk("end_frame_one_cycle", 64'(prev_ef), 64'd0);
            end
            if (valid_out) begin
                if (!prev_valid) chk("first_word_latency", 64'(beat_hist[1]), 64'd1);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL extra_word: got %0h expected no word", data_out);
                end else begin
                    chk("stream_word", data_out, exp_q[0]);
                    if (ready_in) void'(exp_q.pop_front());
                end
            end
            prev_pop   = valid_out && ready_in;
            prev_valid = valid_out;
            prev_ef    = end_frame;
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        int a0;
        int r0;
        int s0;
        int e0;
        reset_n        = 1'b1;
        start_frame    = 1'b0;
        buf_sel        = 1'b0;
        ready_in       = 1'b1;
        reg_addr_buf_1 = 32'h0000_0100;
        reg_addr_buf_2 = 32'h1FFF_FFE0;
        #1 reset_n = 1'b0;
        #3;
        check_reset_outputs("reset");
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        // basic frame from buffer 1
        a0 = accepts;
        exp_addr_q = '{29'h100, 29'h120, 29'h140, 29'h160};
        load_frame(29'h100);
        start(1'b0);
        chk("basic_busy_after_start", 64'(busy), 64'd1);
        wait_end("basic");
        post_frame("basic", a0);

        // buffer 2 with address wrap
        a0 = accepts;
        exp_addr_q = '{29'h1FFF_FFE0, 29'h0, 29'h20, 29'h40};
        load_frame(29'h1FFF_FFE0);
        start(1'b1);
        wait_end("bufsel");
        post_frame("bufsel", a0);

        // waitrequest held for 5 cycles on the first request
        a0 = accepts;
        s0 = stall_used;
        reg_addr_buf_1 = 32'h0000_4000;
        stall_budget = stall_used + 5;
        exp_addr_q = '{29'h4000, 29'h4020, 29'h4040, 29'h4060};
        load_frame(29'h4000);
        start(1'b0);
        wait_end("stall");
        chk("stall_cycles", 64'(stall_used - s0), 64'd5);
        post_frame("stall", a0);

        // full backpressure
        a0 = accepts;
        ready_in = 1'b0;
        reg_addr_buf_1 = 32'h0000_0100;
        exp_addr_q = '{29'h100, 29'h120, 29'h140, 29'h160};
        load_frame(29'h100);
        start(1'b0);
        repeat (150) tick();
        r0 = read_high;
        repeat (150) tick();
        chk("bp_bursts_issued", 64'(accepts - a0), 64'd2);
        chk("bp_read_stays_low", 64'(read_high - r0), 64'd0);
        chk("bp_valid_held", 64'(valid_out), 64'd1);
        chk("bp_words_pending", 64'(exp_q.size()), 64'(FW));
        ready_in = 1'b1;
        wait_end("bp");
        post_frame("bp", a0);

        // spurious beat while idle
        tick();
        spur_cnt++;
        repeat (4) tick();
        chk("spur_flag_set", 64'(err_spurious), 64'd1);
        chk("spur_no_word", 64'(valid_out), 64'd0);
        chk("spur_idle", 64'(busy), 64'd0);
        a0 = accepts;
        exp_addr_q = '{29'h100, 29'h120, 29'h140, 29'h160};
        load_frame(29'h100);
        start(1'b0);
        repeat (2) tick();
        chk("spur_flag_cleared", 64'(err_spurious), 64'd0);
        wait_end("spur");
        post_frame("spur", a0);

        // start while busy is ignored, then reset mid-frame
        reg_addr_buf_1 = 32'h0000_8000;
        reg_addr_buf_2 = 32'h1000_0000;
        exp_addr_q = '{29'h8000, 29'h8020, 29'h8040, 29'h8060};
        load_frame(29'h8000);
        start(1'b0);
        repeat (5) tick();
        start(1'b1);
        repeat (40) tick();
        chk("overlap_still_busy", 64'(busy), 64'd1);
        chk("overlap_frame_unfinished", 64'(exp_q.size() > 0), 64'd1);
        e0 = ef_count;
        #2 reset_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (2) tick();
        chk("midreset_no_end_frame", 64'(ef_count - e0), 64'd0);
        chk("midreset_idle", 64'(busy), 64'd0);

        // fresh frame after reset
        a0 = accepts;
        exp_addr_q = '{29'h8000, 29'h8020, 29'h8040, 29'h8060};
        load_frame(29'h8000);
        start(1'b0);
        wait_end("fresh");
        post_frame("fresh", a0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_read_frame.md
Name: sdram_read_frame

Overview:
Avalon-MM burst read master that fetches one full frame from one of two DDR frame buffers and delivers it as a 64-bit valid/ready stream. It is the read-side counterpart of the frame writer and feeds the HDR/video output pipeline from the HPS SDRAM port. Read requests are credit-limited by an internal FIFO, so no readdatavalid beat is ever dropped.

Parameters:
BURST_LEN, 32, words per Avalon burst; also the per-burst address increment.
FRAME_BURSTS, 2400, bursts per frame; frame = FRAME_BURSTS*BURST_LEN words.
FIFO_DEPTH, 128, internal FIFO depth in 64-bit words; power of 2, >= 2*BURST_LEN.

Ports:
clk_200  in  1  single clock for all logic.
reset_n  in  1  asynchronous reset, active low.
start_frame  in  1  one-cycle pulse that starts a frame read.
buf_sel  in  1  sampled with start_frame: 0 selects reg_addr_buf_1, 1 selects reg_addr_buf_2.
reg_addr_buf_1  in  32  word address of buffer 1; bits [28:0] are used.
reg_addr_buf_2  in  32  word address of buffer 2; bits [28:0] are used.
avl_address  out  29  Avalon read address.
avl_read  out  1  Avalon read request.
avl_burstcount  out  8  constant BURST_LEN.
avl_byteenable  out  8  constant 8'hFF.
avl_waitrequest  in  1  slave stall.
avl_readdata  in  64  read data.
avl_readdatavalid  in  1  read data beat valid.
data_out  out  64  stream data.
valid_out  out  1  stream valid.
ready_in  in  1  downstream ready.
busy  out  1  high from start_frame acceptance until end_frame.
end_frame  out  1  one-cycle pulse when the last frame word is transferred.
err_spurious  out  1  sticky flag: readdatavalid received with no outstanding beats; cleared by the next accepted start_frame.

Behaviour:
- Reset values: all outputs are 0, except avl_burstcount = BURST_LEN and avl_byteenable = 8'hFF. The FSM is in IDLE and the FIFO is empty. Asserting reset mid-frame aborts the frame immediately, with no end_frame pulse.
- FSM states: IDLE, CHECK, REQ, DRAIN.
- IDLE:
  - On start_frame, latch the base address selected by buf_sel into addr.
  - Set bursts_left = FRAME_BURSTS and beats_left = FRAME_BURSTS*BURST_LEN.
  - Clear err_spurious, set busy, go to REQ.
  - avl_read is therefore high in the cycle after start_frame.
- CHECK:
  - If bursts_left == 0, go to DRAIN.
  - Otherwise, if fifo_used + outstanding + BURST_LEN <= FIFO_DEPTH, go to REQ; else stay in CHECK.
- REQ:
  - avl_read = 1 and avl_address = addr; both are held stable while avl_waitrequest = 1.
  - On a cycle with avl_waitrequest = 0: addr += BURST_LEN (29-bit wrap), bursts_left -= 1, outstanding += BURST_LEN, go to CHECK.
  - avl_read is low for at least one cycle between bursts.
- DRAIN: when beats_left == 0 and the FIFO is empty, pulse end_frame, clear busy, go to IDLE.
- Readdatavalid handling, in any state:
  - If outstanding > 0, push avl_readdata into the FIFO, outstanding -= 1, beats_left -= 1.
  - If outstanding == 0, discard the beat and set err_spurious.
  - When a burst is accepted and a beat arrives in the same cycle, the net change is outstanding += BURST_LEN-1.
- The credit rule guarantees that a push never meets a full FIFO.
- FIFO / stream:
  - The FIFO is show-ahead, with registered data_out/valid_out.
  - A word is transferred when valid_out & ready_in.
  - Latency from the first readdatavalid beat to valid_out is 1 cycle.
  - data_out holds stable while valid_out & !ready_in.
  - Simultaneous push and pop leaves fifo_used unchanged.
- end_frame is asserted in the cycle after the final word's handshake.
- A start_frame while busy = 1 is ignored, with no state change.
- Counter widths: outstanding, log2(FIFO_DEPTH)+1 bits; bursts_left 16 bits; beats_left 24 bits.

Test Plan:
- Basic frame: FRAME_BURSTS = 4, buf_sel = 0, reg_addr_buf_1 = 0x100, waitrequest = 0, ready_in = 1, slave returns 32 beats per burst 2 cycles after accept. Required: addresses 0x100, 0x120, 0x140, 0x160; 128 words out in order; one end_frame pulse; busy low afterwards.
- Buffer select: buf_sel = 1, reg_addr_buf_2 = 0x1FFFFFE0. Required: first address 0x1FFFFFE0, second address wraps to 0x00000000.
- Waitrequest stall: hold waitrequest = 1 for 5 cycles during the first request. Required: avl_read and avl_address remain stable for the whole stall; exactly one burst is accepted.
- Backpressure: ready_in = 0 throughout, FIFO_DEPTH = 64. Required: at most 2 bursts are issued and avl_read stays low afterwards; releasing ready_in lets the frame complete with no word lost or duplicated.
- Spurious beat: assert readdatavalid in IDLE. Required: err_spurious = 1 and the FIFO stays empty; the next start_frame clears the flag.
- Reset and overlap: assert start_frame while busy, then assert reset_n = 0 mid-frame. Required: the second start_frame is ignored; reset drives all outputs to their reset values with no end_frame; a fresh start_frame runs a full frame.
